// File: rtl/k6502_int_ctrl_if.sv
// Signal bundle between the k6502 interrupt controller and its pins, peripherals and mcode.
// The master side drives requests, sync and ack; the slave (the controller) drives the sequence outputs.
interface k6502_int_ctrl_if #(
  parameter int NUM_IRQ = 4
);
  logic               sync;
  logic               i_flag;
  logic               nmi_n;
  logic [NUM_IRQ-1:0] irq_n;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic               ack;

  logic               rst;
  logic               nmi;
  logic               irq;
  logic [7:0]         vec_lo;
  logic [2:0]         irq_id;
  logic [NUM_IRQ-1:0] pending;
  logic               busy;

  modport master (
    output sync, i_flag, nmi_n, irq_n, mask_we, mask_wdata, ack,
    input  rst, nmi, irq, vec_lo, irq_id, pending, busy
  );

  modport slave (
    input  sync, i_flag, nmi_n, irq_n, mask_we, mask_wdata, ack,
    output rst, nmi, irq, vec_lo, irq_id, pending, busy
  );
endinterface

// File: rtl/k6502_int_ctrl.sv
// Interrupt sequencer for the k6502: synchronises NMI/IRQ pins, arbitrates at instruction boundaries,
// and holds one-hot rst/nmi/irq plus vector byte and source id until mcode acks the vector fetch.
module k6502_int_ctrl #(
  parameter int         NUM_IRQ     = 4,
  parameter int         SYNC_STAGES = 2,
  parameter int         VECTOR_MODE = 0,
  parameter logic [7:0] VEC_RST     = 8'hFC,
  parameter logic [7:0] VEC_NMI     = 8'hFA,
  parameter logic [7:0] VEC_IRQ     = 8'hFE,
  parameter logic [7:0] VEC_TBL     = 8'hF8
) (
  input logic              clk,
  input logic              rst_n,
  k6502_int_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RST_SEQ = 2'd0,
    IDLE    = 2'd1,
    NMI_SEQ = 2'd2,
    IRQ_SEQ = 2'd3
  } state_e;

  state_e                                  state_q, state_d;
  logic [SYNC_STAGES-1:0]                  nmi_sync_q;
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0]     irq_sync_q;
  logic                                    nmi_prev_q;
  logic                                    nmi_lat_q, nmi_lat_d;
  logic [NUM_IRQ-1:0]                      mask_q;
  logic [NUM_IRQ-1:0]                      pending_q;
  logic [2:0]                              irq_id_q, irq_id_d;
  logic [7:0]                              vec_q, vec_d;

  logic                                    nmi_s;
  logic                                    nmi_fall;
  logic [NUM_IRQ-1:0]                      req;
  logic [2:0]                              win_id;
  logic                                    nmi_take;

  // Synchronisers idle high so that reset release never looks like a falling NMI edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nmi_sync_q <= '1;
      irq_sync_q <= '1;
    end else begin
      nmi_sync_q[0] <= bus.nmi_n;
      irq_sync_q[0] <= bus.irq_n;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        nmi_sync_q[s] <= nmi_sync_q[s-1];
        irq_sync_q[s] <= irq_sync_q[s-1];
      end
    end
  end

  assign nmi_s    = nmi_sync_q[SYNC_STAGES-1];
  assign nmi_fall = nmi_prev_q & ~nmi_s;
  assign req      = ~irq_sync_q[SYNC_STAGES-1] & mask_q;

  always_comb begin
    win_id = 3'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        win_id = 3'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    nmi_take = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.sync) begin
          if (nmi_lat_q) begin
            state_d  = NMI_SEQ;
            nmi_take = 1'b1;
          end else if (|req && !bus.i_flag) begin
            state_d  = IRQ_SEQ;
            irq_id_d = win_id;
          end
        end
      end
      default: begin
        // A sync arriving with ack only returns to IDLE; arbitration waits for the next boundary.
        if (bus.ack) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Clearing on NMI entry wins over a simultaneous edge: that edge merges into the one being serviced.
  assign nmi_lat_d = nmi_take ? 1'b0 : (nmi_lat_q | nmi_fall);

  always_comb begin
    vec_d = VEC_IRQ;
    case (state_d)
      RST_SEQ: vec_d = VEC_RST;
      NMI_SEQ: vec_d = VEC_NMI;
      IRQ_SEQ: vec_d = (VECTOR_MODE == 1) ? 8'(VEC_TBL - {4'b0000, irq_id_d, 1'b0}) : VEC_IRQ;
      default: vec_d = VEC_IRQ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RST_SEQ;
      nmi_prev_q <= 1'b1;
      nmi_lat_q  <= 1'b0;
      mask_q     <= '1;
      pending_q  <= '0;
      irq_id_q   <= 3'd0;
      vec_q      <= VEC_RST;
    end else begin
      state_q    <= state_d;
      nmi_prev_q <= nmi_s;
      nmi_lat_q  <= nmi_lat_d;
      pending_q  <= req;
      irq_id_q   <= irq_id_d;
      vec_q      <= vec_d;
      if (bus.mask_we) begin
        mask_q <= bus.mask_wdata;
      end
    end
  end

  assign bus.rst     = (state_q == RST_SEQ);
  assign bus.nmi     = (state_q == NMI_SEQ);
  assign bus.irq     = (state_q == IRQ_SEQ);
  assign bus.busy    = (state_q != IDLE);
  assign bus.vec_lo  = vec_q;
  assign bus.irq_id  = irq_id_q;
  assign bus.pending = pending_q;

  a_onehot_seq: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({bus.rst, bus.nmi, bus.irq}));

  a_id_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == IRQ_SEQ && !bus.ack) |=> $stable(irq_id_q) && $stable(vec_q));

endmodule

// File: tb/tb_k6502_int_ctrl.sv
module tb_k6502_int_ctrl;
  localparam int NI = 4;
  localparam logic [2:0] S_RST = 3'b100;
  localparam logic [2:0] S_NMI = 3'b010;
  localparam logic [2:0] S_IRQ = 3'b001;

  typedef struct packed {
    logic [2:0] seq;
    logic [2:0] id;
    logic [7:0] vec;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  k6502_int_ctrl_if #(.NUM_IRQ(NI)) bus ();

  k6502_int_ctrl #(
    .NUM_IRQ(NI), .SYNC_STAGES(2), .VECTOR_MODE(1),
    .VEC_RST(8'hFC), .VEC_NMI(8'hFA), .VEC_IRQ(8'hFE), .VEC_TBL(8'hF8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Scoreboard: every newly started sequence must match the oldest expected entry.
  always begin : monitor
    logic [2:0] cur;
    logic [2:0] prev_seq;
    exp_t       e;
    prev_seq = 3'b000;
    forever begin
      @(posedge clk);
      #1;
      cur = {bus.rst, bus.nmi, bus.irq};
      if (!$isunknown(cur) && cur != 3'b000 && cur != prev_seq) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected got seq=%b vec=%h id=%0d, no sequence expected", cur, bus.vec_lo, bus.irq_id);
        end else begin
          e = sb_q.pop_front();
          if (cur !== e.seq || bus.vec_lo !== e.vec || (e.seq == S_IRQ && bus.irq_id !== e.id)) begin
            failures++;
            $display("FAIL sb_seq got seq=%b vec=%h id=%0d exp seq=%b vec=%h id=%0d",
                     cur, bus.vec_lo, bus.irq_id, e.seq, e.vec, e.id);
          end
        end
      end
      prev_seq = $isunknown(cur) ? 3'b000 : cur;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sync();
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
  endtask

  task automatic push(input logic [2:0] seq, input logic [2:0] id, input logic [7:0] vec);
    exp_t e;
    e.seq = seq;
    e.id  = id;
    e.vec = vec;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    push(S_RST, 3'd0, 8'hFC);
    repeat (2) tick();
    checks++; if ({bus.rst, bus.nmi, bus.irq, bus.busy} !== 4'b1001) begin failures++; $display("FAIL reset_flags got=%b exp=1001", {bus.rst, bus.nmi, bus.irq, bus.busy}); end
    checks++; if (bus.vec_lo !== 8'hFC) begin failures++; $display("FAIL reset_vec got=%h exp=fc", bus.vec_lo); end
    checks++; if (bus.irq_id !== 3'd0 || bus.pending !== 4'b0000) begin failures++; $display("FAIL reset_id_pend got id=%0d pend=%b exp 0/0000", bus.irq_id, bus.pending); end
    rst_n = 1'b1;
    tick();
    do_sync();
    checks++; if (bus.rst !== 1'b1 || bus.vec_lo !== 8'hFC) begin failures++; $display("FAIL rst_hold got rst=%b vec=%h exp 1/fc", bus.rst, bus.vec_lo); end
    do_ack();
    checks++; if (bus.busy !== 1'b0 || bus.rst !== 1'b0) begin failures++; $display("FAIL rst_ack got busy=%b rst=%b exp 0/0", bus.busy, bus.rst); end
    checks++; if (bus.vec_lo !== 8'hFE) begin failures++; $display("FAIL idle_vec got=%h exp=fe", bus.vec_lo); end
    do_ack();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_ack got busy=%b exp=0", bus.busy); end
  endtask

  task automatic test_nmi();
    bus.nmi_n = 1'b0;
    repeat (4) tick();
    push(S_NMI, 3'd0, 8'hFA);
    do_sync();
    checks++; if (bus.nmi !== 1'b1 || bus.vec_lo !== 8'hFA || bus.busy !== 1'b1) begin failures++; $display("FAIL nmi_enter got nmi=%b vec=%h busy=%b exp 1/fa/1", bus.nmi, bus.vec_lo, bus.busy); end
    bus.nmi_n = 1'b1;
    repeat (3) tick();
    bus.nmi_n = 1'b0;
    repeat (4) tick();
    checks++; if (bus.nmi !== 1'b1) begin failures++; $display("FAIL nmi_hold got=%b exp=1", bus.nmi); end
    do_ack();
    repeat (2) tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL nmi_wait_sync got busy=%b exp=0", bus.busy); end
    push(S_NMI, 3'd0, 8'hFA);
    do_sync();
    checks++; if (bus.nmi !== 1'b1) begin failures++; $display("FAIL nmi_second got=%b exp=1", bus.nmi); end
    do_ack();
    bus.nmi_n = 1'b1;
    repeat (3) tick();
    do_sync();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL nmi_no_third got busy=%b exp=0", bus.busy); end
  endtask

  task automatic test_irq();
    bus.irq_n  = 4'b0101;
    bus.i_flag = 1'b1;
    repeat (3) tick();
    checks++; if (bus.pending !== 4'b1010) begin failures++; $display("FAIL irq_pending got=%b exp=1010", bus.pending); end
    do_sync();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL irq_iflag got busy=%b exp=0", bus.busy); end
    bus.i_flag = 1'b0;
    push(S_IRQ, 3'd1, 8'hF6);
    do_sync();
    checks++; if (bus.irq !== 1'b1 || bus.irq_id !== 3'd1 || bus.vec_lo !== 8'hF6) begin failures++; $display("FAIL irq_enter got irq=%b id=%0d vec=%h exp 1/1/f6", bus.irq, bus.irq_id, bus.vec_lo); end
    bus.irq_n = 4'b1111;
    repeat (3) tick();
    checks++; if (bus.irq !== 1'b1 || bus.irq_id !== 3'd1 || bus.vec_lo !== 8'hF6) begin failures++; $display("FAIL irq_release_hold got irq=%b id=%0d vec=%h exp 1/1/f6", bus.irq, bus.irq_id, bus.vec_lo); end
    do_ack();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL irq_ack got busy=%b exp=0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    bus.irq_n = 4'b1110;
    repeat (3) tick();
    push(S_IRQ, 3'd0, 8'hF8);
    do_sync();
    bus.sync = 1'b1;
    bus.ack  = 1'b1;
    tick();
    bus.sync = 1'b0;
    bus.ack  = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL sync_ack_idle got busy=%b exp=0", bus.busy); end
    tick();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL sync_ack_noarb got busy=%b exp=0", bus.busy); end
    push(S_IRQ, 3'd0, 8'hF8);
    do_sync();
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 4'b1110;
    tick();
    bus.mask_we = 1'b0;
    tick();
    checks++; if (bus.pending !== 4'b0000) begin failures++; $display("FAIL mask_mid_pend got=%b exp=0000", bus.pending); end
    checks++; if (bus.irq !== 1'b1 || bus.irq_id !== 3'd0 || bus.vec_lo !== 8'hF8) begin failures++; $display("FAIL mask_mid_hold got irq=%b id=%0d vec=%h exp 1/0/f8", bus.irq, bus.irq_id, bus.vec_lo); end
    do_ack();
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 4'b1111;
    tick();
    bus.mask_we = 1'b0;
    bus.irq_n   = 4'b1111;
    repeat (3) tick();
  endtask

  task automatic test_mask();
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 4'b1101;
    bus.irq_n      = 4'b1101;
    tick();
    bus.mask_we = 1'b0;
    repeat (3) tick();
    checks++; if (bus.pending !== 4'b0000) begin failures++; $display("FAIL mask_pend got=%b exp=0000", bus.pending); end
    do_sync();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mask_no_irq got busy=%b exp=0", bus.busy); end
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 4'b1111;
    tick();
    bus.mask_we = 1'b0;
    tick();
    checks++; if (bus.pending !== 4'b0010) begin failures++; $display("FAIL unmask_pend got=%b exp=0010", bus.pending); end
    bus.irq_n = 4'b1111;
    repeat (3) tick();
  endtask

  task automatic test_nmi_irq_same();
    bus.nmi_n = 1'b0;
    bus.irq_n = 4'b1110;
    repeat (4) tick();
    push(S_NMI, 3'd0, 8'hFA);
    push(S_IRQ, 3'd0, 8'hF8);
    do_sync();
    checks++; if (bus.nmi !== 1'b1 || bus.irq !== 1'b0) begin failures++; $display("FAIL prio_nmi got nmi=%b irq=%b exp 1/0", bus.nmi, bus.irq); end
    do_ack();
    do_sync();
    checks++; if (bus.irq !== 1'b1 || bus.irq_id !== 3'd0) begin failures++; $display("FAIL prio_irq_after got irq=%b id=%0d exp 1/0", bus.irq, bus.irq_id); end
    do_ack();
    bus.nmi_n = 1'b1;
    bus.irq_n = 4'b1111;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid();
    bus.irq_n = 4'b1110;
    repeat (3) tick();
    push(S_IRQ, 3'd0, 8'hF8);
    do_sync();
    bus.nmi_n      = 1'b0;
    bus.mask_we    = 1'b1;
    bus.mask_wdata = 4'b0000;
    tick();
    bus.mask_we = 1'b0;
    repeat (3) tick();
    bus.nmi_n = 1'b1;
    tick();
    push(S_RST, 3'd0, 8'hFC);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.rst !== 1'b1 || bus.irq !== 1'b0 || bus.vec_lo !== 8'hFC) begin failures++; $display("FAIL async_rst got rst=%b irq=%b vec=%h exp 1/0/fc", bus.rst, bus.irq, bus.vec_lo); end
    tick();
    rst_n = 1'b1;
    do_ack();
    repeat (3) tick();
    checks++; if (bus.pending !== 4'b0001) begin failures++; $display("FAIL rst_mask_restored got pend=%b exp=0001", bus.pending); end
    push(S_IRQ, 3'd0, 8'hF8);
    do_sync();
    checks++; if (bus.irq !== 1'b1 || bus.nmi !== 1'b0) begin failures++; $display("FAIL rst_latch_cleared got irq=%b nmi=%b exp 1/0", bus.irq, bus.nmi); end
    do_ack();
    bus.irq_n = 4'b1111;
    repeat (2) tick();
  endtask

  initial begin
    bus.sync       = 1'b0;
    bus.i_flag     = 1'b0;
    bus.nmi_n      = 1'b1;
    bus.irq_n      = 4'b1111;
    bus.mask_we    = 1'b0;
    bus.mask_wdata = 4'b1111;
    bus.ack        = 1'b0;
    test_reset();
    test_nmi();
    test_irq();
    test_back_to_back();
    test_mask();
    test_nmi_irq_same();
    test_reset_mid();
    tick();
    checks++; if (sb_q.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
